// File: rtl/id_rr_hazard_ctrl.sv
// rtl/id_rr_hazard_ctrl.sv - ID/RR pipeline register hazard, serialization and flush controller
module id_rr_hazard_ctrl #(
  parameter int LAT_W        = 3,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_bar,
  input  logic             id_valid,
  input  logic [2:0]       id_src1_idx,
  input  logic [2:0]       id_src2_idx,
  input  logic             id_use1,
  input  logic             id_use2,
  input  logic             id_serial,
  input  logic             rr_valid,
  input  logic             rr_wr_en,
  input  logic [2:0]       rr_dst_idx,
  input  logic [LAT_W-1:0] rr_lat,
  input  logic             wb_valid,
  input  logic [2:0]       wb_idx,
  input  logic             redirect,
  output logic             stall,
  output logic             flush,
  output logic [7:0]       sb_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SERIAL = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  state_t           state, state_nxt;
  logic [LAT_W-1:0] cnt [8];
  logic [2:0]       flush_cnt;
  logic [7:0]       sb_raw;
  logic [LAT_W-1:0] lat_eff;
  logic             issue;
  logic             busy1, busy2;
  logic             raw;
  logic             stall_c;

  // A squashed RR instruction must not reserve its destination.
  assign issue   = rr_valid & rr_wr_en & (state != FLUSH);
  assign lat_eff = (rr_lat == '0) ? LAT_W'(1) : rr_lat;

  // Per-register busy flags straight from the countdown registers.
  always_comb begin
    sb_raw = '0;
    for (int n = 0; n < 8; n++) begin
      sb_raw[n] = (cnt[n] != '0);
    end
  end

  // RR writer counts as busy in the same cycle, before its countdown is loaded.
  assign busy1 = sb_raw[id_src1_idx] | (rr_valid & rr_wr_en & (rr_dst_idx == id_src1_idx));
  assign busy2 = sb_raw[id_src2_idx] | (rr_valid & rr_wr_en & (rr_dst_idx == id_src2_idx));
  assign raw   = id_valid & ((id_use1 & busy1) | (id_use2 & busy2));

  // Countdown scoreboard: issue beats writeback clear beats decrement.
  always_ff @(posedge clk) begin
    if (!rst_bar) begin
      for (int n = 0; n < 8; n++) cnt[n] <= '0;
    end else begin
      for (int n = 0; n < 8; n++) begin
        if (issue && (rr_dst_idx == 3'(n)))
          cnt[n] <= lat_eff;
        else if (wb_valid && (wb_idx == 3'(n)))
          cnt[n] <= '0;
        else if (cnt[n] != '0)
          cnt[n] <= cnt[n] - LAT_W'(1);
      end
    end
  end

  // Next-state and stall decode; redirect overrides whatever the state wanted.
  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    case (state)
      RUN: begin
        stall_c = raw;
        if (id_valid && id_serial && ((sb_raw != '0) || rr_valid)) begin
          stall_c   = 1'b1;
          state_nxt = SERIAL;
        end
      end
      SERIAL: begin
        stall_c = 1'b1;
        if ((sb_raw == '0) && !rr_valid) state_nxt = RUN;
      end
      FLUSH: begin
        if (flush_cnt <= 3'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (redirect) state_nxt = FLUSH;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_bar) state <= RUN;
    else          state <= state_nxt;
  end

  // Flush length counter, reloaded by every redirect.
  always_ff @(posedge clk) begin
    if (!rst_bar)
      flush_cnt <= '0;
    else if (redirect)
      flush_cnt <= FLUSH_LOAD;
    else if ((state == FLUSH) && (flush_cnt != '0))
      flush_cnt <= flush_cnt - 3'd1;
  end

  // Outputs are forced quiet while reset is held.
  assign stall   = rst_bar & stall_c;
  assign flush   = rst_bar & (state == FLUSH);
  assign sb_busy = rst_bar ? sb_raw : 8'h00;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (!rst_bar)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_rr_hazard_ctrl.sv
// tb/tb_id_rr_hazard_ctrl.sv - directed self-checking bench for id_rr_hazard_ctrl
module tb_id_rr_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_bar;
  logic        id_valid, id_use1, id_use2, id_serial;
  logic [2:0]  id_src1_idx, id_src2_idx;
  logic        rr_valid, rr_wr_en;
  logic [2:0]  rr_dst_idx;
  logic [2:0]  rr_lat;
  logic        wb_valid;
  logic [2:0]  wb_idx;
  logic        redirect;
  logic        stall, flush;
  logic [7:0]  sb_busy;
  logic [15:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_rr_hazard_ctrl #(.LAT_W(3), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_bar(rst_bar),
    .id_valid(id_valid), .id_src1_idx(id_src1_idx), .id_src2_idx(id_src2_idx),
    .id_use1(id_use1), .id_use2(id_use2), .id_serial(id_serial),
    .rr_valid(rr_valid), .rr_wr_en(rr_wr_en), .rr_dst_idx(rr_dst_idx), .rr_lat(rr_lat),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .redirect(redirect),
    .stall(stall), .flush(flush), .sb_busy(sb_busy), .stall_cycles(stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic clear_inputs;
    id_valid = 0; id_use1 = 0; id_use2 = 0; id_serial = 0;
    id_src1_idx = 0; id_src2_idx = 0;
    rr_valid = 0; rr_wr_en = 0; rr_dst_idx = 0; rr_lat = 0;
    wb_valid = 0; wb_idx = 0; redirect = 0;
  endtask

  initial begin
    clear_inputs();
    rst_bar = 0;
    tick(); tick();
    settle();
    check("rst_stall", stall, 0);
    check("rst_flush", flush, 0);
    check("rst_sb_busy", sb_busy, 0);
    rst_bar = 1;
    tick();
    settle();
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_sb_busy_after", sb_busy, 0);

    // 1: issue r3 lat 2 with a reader of r3 waiting in ID
    rr_valid = 1; rr_wr_en = 1; rr_dst_idx = 3; rr_lat = 2;
    id_valid = 1; id_use1 = 1; id_src1_idx = 3;
    settle();
    check("t1_stall_issue_cycle", stall, 1);
    tick();
    rr_valid = 0; rr_wr_en = 0;
    settle();
    check("t1_sb_busy_c1", sb_busy, 8'h08);
    check("t1_stall_c1", stall, 1);
    tick(); settle();
    check("t1_sb_busy_c2", sb_busy, 8'h08);
    check("t1_stall_c2", stall, 1);
    tick(); settle();
    check("t1_sb_busy_c3", sb_busy, 8'h00);
    check("t1_stall_c3", stall, 0);
    check("t1_stall_cycles", stall_cycles, 3);
    clear_inputs();
    tick();

    // 2: issue r5 lat 7, writeback clears it two cycles later
    rr_valid = 1; rr_wr_en = 1; rr_dst_idx = 5; rr_lat = 7;
    tick();
    rr_valid = 0; rr_wr_en = 0;
    tick();
    wb_valid = 1; wb_idx = 5;
    id_valid = 1; id_use1 = 1; id_src1_idx = 5;
    settle();
    check("t2_stall_before_wb", stall, 1);
    check("t2_sb_busy_before_wb", sb_busy, 8'h20);
    tick();
    wb_valid = 0;
    settle();
    check("t2_sb_busy_after_wb", sb_busy, 8'h00);
    check("t2_stall_after_wb", stall, 0);
    clear_inputs();
    tick();

    // 3: issue to r2 and writeback r2 in the same cycle; issue wins
    rr_valid = 1; rr_wr_en = 1; rr_dst_idx = 2; rr_lat = 3;
    wb_valid = 1; wb_idx = 2;
    tick();
    clear_inputs();
    settle();
    check("t3_busy_c1", sb_busy, 8'h04);
    tick(); tick(); settle();
    check("t3_busy_c3", sb_busy, 8'h04);
    tick(); settle();
    check("t3_busy_c4", sb_busy, 8'h00);

    // 4: serializing instruction waits for r1 (lat 4) to drain
    rr_valid = 1; rr_wr_en = 1; rr_dst_idx = 1; rr_lat = 4;
    tick();
    rr_valid = 0; rr_wr_en = 0;
    id_valid = 1; id_serial = 1;
    settle();
    check("t4_stall_enter", stall, 1);
    tick(); settle();
    check("t4_stall_serial_c2", stall, 1);
    tick(); settle();
    check("t4_stall_serial_c3", stall, 1);
    tick(); settle();
    check("t4_stall_serial_c4", stall, 1);
    check("t4_sb_busy_c4", sb_busy, 8'h02);
    tick(); settle();
    check("t4_stall_serial_drain", stall, 1);
    check("t4_sb_busy_drain", sb_busy, 8'h00);
    tick(); settle();
    check("t4_stall_run", stall, 0);
    check("t4_flush_run", flush, 0);
    check("t4_stall_cycles", stall_cycles, 9);
    clear_inputs();
    tick();

    // 5: redirect during SERIAL with r4 busy (lat 6), FLUSH_CYCLES=2
    rr_valid = 1; rr_wr_en = 1; rr_dst_idx = 4; rr_lat = 6;
    tick();
    rr_valid = 0; rr_wr_en = 0;
    id_valid = 1; id_serial = 1;
    settle();
    check("t5_stall_enter", stall, 1);
    tick();
    redirect = 1;
    settle();
    check("t5_stall_redirect_cycle", stall, 1);
    check("t5_flush_redirect_cycle", flush, 0);
    tick();
    redirect = 0;
    rr_valid = 1; rr_wr_en = 1; rr_dst_idx = 6; rr_lat = 3;
    settle();
    check("t5_flush_c1", flush, 1);
    check("t5_stall_c1", stall, 0);
    check("t5_sb_busy_c1", sb_busy, 8'h10);
    tick(); settle();
    check("t5_flush_c2", flush, 1);
    check("t5_stall_c2", stall, 0);
    check("t5_sb_busy_c2", sb_busy, 8'h10);
    tick();
    clear_inputs();
    settle();
    check("t5_flush_done", flush, 0);
    check("t5_sb_busy_c3", sb_busy, 8'h10);
    check("t5_stall_cycles", stall_cycles, 11);
    tick(); settle();
    check("t5_sb_busy_c4", sb_busy, 8'h10);
    tick(); settle();
    check("t5_sb_busy_c5", sb_busy, 8'h00);

    // reset while in FLUSH
    redirect = 1;
    tick();
    redirect = 0;
    settle();
    check("rf_flush_set", flush, 1);
    rst_bar = 0;
    settle();
    check("rf_flush_in_reset", flush, 0);
    tick();
    rst_bar = 1;
    settle();
    check("rf_flush_after_reset", flush, 0);
    tick();

    // 6: saturate the stall counter with a permanent bypass hazard on r0
    rr_valid = 1; rr_wr_en = 1; rr_dst_idx = 0; rr_lat = 1;
    id_valid = 1; id_use1 = 1; id_src1_idx = 0;
    for (int i = 0; i < 65541; i++) tick();
    settle();
    check("t6_stall_held", stall, 1);
    check("t6_stall_cycles_sat", stall_cycles, 16'hFFFF);
    rst_bar = 0;
    settle();
    check("t6_stall_in_reset", stall, 0);
    check("t6_flush_in_reset", flush, 0);
    check("t6_sb_busy_in_reset", sb_busy, 8'h00);
    tick();
    clear_inputs();
    rst_bar = 1;
    settle();
    check("t6_stall_cycles_after", stall_cycles, 0);
    check("t6_sb_busy_after", sb_busy, 8'h00);
    check("t6_stall_after", stall, 0);
    check("t6_flush_after", flush, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_rr_hazard_ctrl.md
Name: id_rr_hazard_ctrl

Overview:
- Hazard and sequencing controller for the ID/RR pipeline register.
- Tracks in-flight register writes in an 8-entry countdown scoreboard and detects RAW hazards for the instruction waiting in ID.
- Generates the `stall` (hold ID, bubble into RR) and `flush` controls for that register.
- Sequences serializing instructions and branch-redirect flushes.

Parameters:
- LAT_W, 3, width of per-register latency countdown.
- FLUSH_CYCLES, 1, cycles `flush` stays asserted per redirect (1..7).
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  pipeline clock.
- rst_bar  in  1  synchronous active-low reset.
- id_valid  in  1  valid instruction in ID (feeding the ID/RR register).
- id_src1_idx  in  3  ID source 1 register.
- id_src2_idx  in  3  ID source 2 register.
- id_use1  in  1  ID instruction reads src1.
- id_use2  in  1  ID instruction reads src2.
- id_serial  in  1  ID instruction must issue with no writes in flight.
- rr_valid  in  1  valid instruction in RR (ID/RR register output).
- rr_wr_en  in  1  RR instruction writes a register.
- rr_dst_idx  in  3  RR destination register.
- rr_lat  in  LAT_W  cycles until RR result is bypassable (0 treated as 1).
- wb_valid  in  1  writeback this cycle.
- wb_idx  in  3  writeback register.
- redirect  in  1  branch resolved mispredicted (single-cycle pulse).
- stall  out  1  to ID/RR register stall input.
- flush  out  1  to ID/RR register flush input.
- sb_busy  out  8  per-register nonzero-countdown flags.
- stall_cycles  out  CNT_W  saturating count of cycles with stall=1.

Behaviour:

Reset (rst_bar=0 at a clk edge):
- All countdowns=0; state=RUN; flush counter=0; stall_cycles=0.
- While rst_bar=0: stall=0, flush=0, sb_busy=0.

Scoreboard (register n):
- Issue event: `rr_valid & rr_wr_en & state!=FLUSH`. On issue, `cnt[rr_dst_idx] <= max(rr_lat,1)`.
- Otherwise `cnt[n]` decrements by 1 each cycle while nonzero. It never wraps below 0.
- `wb_valid` forces `cnt[wb_idx] <= 0`.
- Priority per entry: issue > writeback clear > decrement.
- `sb_busy[n] = (cnt[n] != 0)`, registered view.

Hazard:
- `busy(r) = sb_busy[r] | (rr_valid & rr_wr_en & rr_dst_idx==r)`.
- `raw = id_valid & ((id_use1 & busy(id_src1_idx)) | (id_use2 & busy(id_src2_idx)))`.
- Register indices are compared at the full 3 bits. There is no special-casing of register 0.

FSM (RUN, SERIAL, FLUSH):
- RUN:
  - `stall = raw`.
  - If `id_valid & id_serial & (sb_busy!=0 | rr_valid)`: stall=1 and go to SERIAL next cycle.
- SERIAL:
  - stall=1 every cycle.
  - Return to RUN the cycle after `sb_busy==0 & ~rr_valid` is observed. The serial instruction then enters RR on that RUN cycle, with raw re-evaluated.
- FLUSH:
  - flush=1 and stall=0.
  - Issue events are suppressed; the RR instruction is being squashed.
  - Existing countdowns continue decrementing and writeback clears still apply, because older in-flight writes are real.
  - Stay for FLUSH_CYCLES cycles, then go to RUN.

Redirect:
- `redirect` in any state means next state=FLUSH and the flush counter reloads to FLUSH_CYCLES.
- flush is asserted starting the cycle after the redirect.
- A redirect during FLUSH restarts the count.
- A redirect during SERIAL abandons the serial wait.
- Redirect and raw in the same cycle: stall follows current-state rules that cycle; FLUSH takes over next cycle.

Other rules:
- stall and flush are never both 1.
- stall is combinational from current state and inputs.
- flush is a decode of registered state only.
- `stall_cycles` increments on each cycle with stall=1 and saturates at all-ones.
- Reset mid-SERIAL or mid-FLUSH returns to RUN with the scoreboard cleared the next cycle.

Test Plan:
1. Reset, then `rr_valid=1, rr_wr_en=1, rr_dst_idx=3, rr_lat=2` for one cycle, then `id_valid=1, id_use1=1, id_src1_idx=3` -> stall=1 in the issue cycle and the next 2 cycles (sb_busy[3]=1 for 2 cycles), then stall=0; stall_cycles=3.
2. Issue to r5 with `rr_lat=7`, then `wb_valid=1, wb_idx=5` two cycles later -> sb_busy[5] drops the next cycle and an ID reader of r5 unstalls immediately.
3. Issue to r2 and, in the same cycle, `wb_valid=1, wb_idx=2` -> issue wins and cnt[2]=rr_lat; r2 stays busy.
4. r1 busy (lat 4); `id_valid=1, id_serial=1, id_use1=0` -> state SERIAL and stall=1 until sb_busy==0 & ~rr_valid, then one RUN cycle with stall=0.
5. `FLUSH_CYCLES=2`; redirect pulse while in SERIAL with r4 busy -> flush=1 for exactly 2 cycles starting next cycle, stall=0 throughout, r4 countdown keeps decrementing, no new scoreboard loads.
6. Force 2^CNT_W+5 stall cycles -> stall_cycles holds at all-ones; drop rst_bar for one edge -> all outputs 0.
